// File: rtl/constraint_sweeper_pkg.sv
// Shared Q16.16 format constants and the sweeper state encoding.
package constraint_sweeper_pkg;

  localparam int unsigned Q_DATA_W    = 32;
  localparam logic [31:0] Q_ONE       = 32'h0001_0000;
  localparam logic [31:0] Q_DOTS_DIST = 32'h0000_f000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD0 = 3'd1,
    S_LOAD1 = 3'd2,
    S_FETCH = 3'd3,
    S_WAIT  = 3'd4,
    S_CALC  = 3'd5,
    S_WRITE = 3'd6,
    S_DONE  = 3'd7
  } sweep_state_e;

endpackage

// File: rtl/constraint_sweeper_window.sv
// Up/cur/down/result register window that slides one point down the chain per WRITE.
module constraint_sweeper_window
  import constraint_sweeper_pkg::*;
#(
  parameter int DATA_W = Q_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_up_i,
  input  logic              load_cur_i,
  input  logic              load_down_i,
  input  logic              load_res_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] rd_x_i,
  input  logic [DATA_W-1:0] rd_y_i,
  input  logic [DATA_W-1:0] res_x_i,
  input  logic [DATA_W-1:0] res_y_i,
  output logic [DATA_W-1:0] up_x_o,
  output logic [DATA_W-1:0] up_y_o,
  output logic [DATA_W-1:0] cur_x_o,
  output logic [DATA_W-1:0] cur_y_o,
  output logic [DATA_W-1:0] down_x_o,
  output logic [DATA_W-1:0] down_y_o,
  output logic [DATA_W-1:0] res_x_o,
  output logic [DATA_W-1:0] res_y_o
);

  logic [DATA_W-1:0] up_x_q, up_y_q, cur_x_q, cur_y_q;
  logic [DATA_W-1:0] down_x_q, down_y_q, res_x_q, res_y_q;

  // Shift moves the freshly enforced point into "up" so the next point sees it (Gauss-Seidel).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_x_q   <= '0;
      up_y_q   <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      down_x_q <= '0;
      down_y_q <= '0;
      res_x_q  <= '0;
      res_y_q  <= '0;
    end else begin
      if (load_up_i) begin
        up_x_q <= rd_x_i;
        up_y_q <= rd_y_i;
      end else if (shift_i) begin
        up_x_q <= res_x_q;
        up_y_q <= res_y_q;
      end
      if (load_cur_i) begin
        cur_x_q <= rd_x_i;
        cur_y_q <= rd_y_i;
      end else if (shift_i) begin
        cur_x_q <= down_x_q;
        cur_y_q <= down_y_q;
      end
      if (load_down_i) begin
        down_x_q <= rd_x_i;
        down_y_q <= rd_y_i;
      end
      if (load_res_i) begin
        res_x_q <= res_x_i;
        res_y_q <= res_y_i;
      end
    end
  end

  assign up_x_o   = up_x_q;
  assign up_y_o   = up_y_q;
  assign cur_x_o  = cur_x_q;
  assign cur_y_o  = cur_y_q;
  assign down_x_o = down_x_q;
  assign down_y_o = down_y_q;
  assign res_x_o  = res_x_q;
  assign res_y_o  = res_y_q;

endmodule

// File: rtl/constraint_sweeper.sv
// Sweeps the chain through the external constraint engine, writing each enforced point back.
// state | meaning
// IDLE  | waiting for start
// LOAD0 | read point 0 (anchor)
// LOAD1 | capture anchor as up, read point 1
// FETCH | capture cur on i==1, read point i+1 unless last
// WAIT  | capture down (unless last), register is_last
// CALC  | register engine result
// WRITE | write result to point i, slide window
// DONE  | one-cycle completion pulse
module constraint_sweeper
  import constraint_sweeper_pkg::*;
#(
  parameter int N_POINTS   = 16,
  parameter int ADDR_W     = 4,
  parameter int ITERATIONS = 4,
  parameter int DATA_W     = Q_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_x_i,
  input  logic [DATA_W-1:0] rd_y_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_x_o,
  output logic [DATA_W-1:0] wr_y_o,
  output logic [DATA_W-1:0] eng_up_x_o,
  output logic [DATA_W-1:0] eng_up_y_o,
  output logic [DATA_W-1:0] eng_x_o,
  output logic [DATA_W-1:0] eng_y_o,
  output logic [DATA_W-1:0] eng_down_x_o,
  output logic [DATA_W-1:0] eng_down_y_o,
  output logic              eng_is_last_o,
  input  logic [DATA_W-1:0] eng_x_new_i,
  input  logic [DATA_W-1:0] eng_y_new_i
);

  localparam int IT_W = $clog2(ITERATIONS + 1);
  localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W-1:0] I_FIRST  = ADDR_W'(1);
  localparam logic [IT_W-1:0]   ITER_MAX = IT_W'(ITERATIONS);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [IT_W-1:0]   iter_q, iter_d, iter_inc;
  logic              is_last_q, is_last_d;
  logic              at_last;
  logic              load_up, load_cur, load_down, load_res, shift;

  assign at_last  = (i_q == I_LAST);
  assign iter_inc = iter_q + IT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      i_q       <= I_FIRST;
      iter_q    <= '0;
      is_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      iter_q    <= iter_d;
      is_last_q <= is_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    iter_d    = iter_q;
    is_last_d = is_last_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD0;
      S_LOAD0: state_d = S_LOAD1;
      S_LOAD1: begin
        i_d     = I_FIRST;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        is_last_d = at_last;
        state_d   = S_CALC;
      end
      S_CALC:  state_d = S_WRITE;
      S_WRITE: begin
        if (!at_last) begin
          i_d     = i_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          i_d     = I_FIRST;
          iter_d  = iter_inc;
          state_d = (iter_inc == ITER_MAX) ? S_DONE : S_LOAD0;
        end
      end
      S_DONE: begin
        iter_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    load_up   = 1'b0;
    load_cur  = 1'b0;
    load_down = 1'b0;
    load_res  = 1'b0;
    shift     = 1'b0;
    case (state_q)
      S_LOAD0: begin
        busy_o  = 1'b1;
        rd_en_o = 1'b1;
      end
      S_LOAD1: begin
        busy_o    = 1'b1;
        rd_en_o   = 1'b1;
        rd_addr_o = I_FIRST;
        load_up   = 1'b1;
      end
      S_FETCH: begin
        busy_o   = 1'b1;
        load_cur = (i_q == I_FIRST);
        if (!at_last) begin
          rd_en_o   = 1'b1;
          rd_addr_o = i_q + ADDR_W'(1);
        end
      end
      S_WAIT: begin
        busy_o    = 1'b1;
        load_down = !at_last;
      end
      S_CALC: begin
        busy_o   = 1'b1;
        load_res = 1'b1;
      end
      S_WRITE: begin
        busy_o    = 1'b1;
        wr_en_o   = 1'b1;
        wr_addr_o = i_q;
        shift     = 1'b1;
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  constraint_sweeper_window #(.DATA_W(DATA_W)) u_window (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_up_i   (load_up),
    .load_cur_i  (load_cur),
    .load_down_i (load_down),
    .load_res_i  (load_res),
    .shift_i     (shift),
    .rd_x_i      (rd_x_i),
    .rd_y_i      (rd_y_i),
    .res_x_i     (eng_x_new_i),
    .res_y_i     (eng_y_new_i),
    .up_x_o      (eng_up_x_o),
    .up_y_o      (eng_up_y_o),
    .cur_x_o     (eng_x_o),
    .cur_y_o     (eng_y_o),
    .down_x_o    (eng_down_x_o),
    .down_y_o    (eng_down_y_o),
    .res_x_o     (wr_x_o),
    .res_y_o     (wr_y_o)
  );

  assign eng_is_last_o = is_last_q;

endmodule
